// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared cause codes, exception-flag indices and FSM encoding
//               for the machine-mode trap controller.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    localparam int DEFAULT_XLEN = 64;

    // mcause exception codes (interrupt flag clear)
    localparam logic [3:0] EXC_IF_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_BREAK       = 4'd3;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ECALL_M     = 4'd11;

    // mcause interrupt codes (interrupt flag set)
    localparam logic [3:0] INT_SOFT  = 4'd3;
    localparam logic [3:0] INT_TIMER = 4'd7;
    localparam logic [3:0] INT_EXTER = 4'd11;

    // wb_excp_i = {st_misalign, ld_misalign, ecall, ebreak, illegal, if_misalign}
    localparam int EXCP_IF_MISALIGN = 0;
    localparam int EXCP_ILLEGAL     = 1;
    localparam int EXCP_EBREAK      = 2;
    localparam int EXCP_ECALL       = 3;
    localparam int EXCP_LD_MISALIGN = 4;
    localparam int EXCP_ST_MISALIGN = 5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TRAP_WR  = 3'd1;
    localparam logic [2:0] ST_TRAP_JMP = 3'd2;
    localparam logic [2:0] ST_MRET_WR  = 3'd3;
    localparam logic [2:0] ST_MRET_JMP = 3'd4;

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : trap_prio_enc
// Description : Combinational priority encoder selecting the interrupt or
//               synchronous exception to take for the WB instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic       wb_valid_i,
    input  logic [5:0] wb_excp_i,
    input  logic       mstatus_ie_i,
    input  logic       mie_soft_i,
    input  logic       mie_timer_i,
    input  logic       mie_exter_i,
    input  logic       mip_soft_i,
    input  logic       mip_timer_i,
    input  logic       mip_exter_i,
    output logic       take_o,
    output logic       is_int_o,
    output logic [3:0] code_o,
    output logic       use_tval_o
);

    logic w_int_exter;
    logic w_int_soft;
    logic w_int_timer;

    assign w_int_exter = mstatus_ie_i & mie_exter_i & mip_exter_i;
    assign w_int_soft  = mstatus_ie_i & mie_soft_i  & mip_soft_i;
    assign w_int_timer = mstatus_ie_i & mie_timer_i & mip_timer_i;

    // Interrupts outrank every synchronous exception
    always_comb begin
        take_o     = 1'b0;
        is_int_o   = 1'b0;
        code_o     = 4'd0;
        use_tval_o = 1'b0;
        if (wb_valid_i) begin
            if (w_int_exter) begin
                take_o = 1'b1; is_int_o = 1'b1; code_o = INT_EXTER;
            end else if (w_int_soft) begin
                take_o = 1'b1; is_int_o = 1'b1; code_o = INT_SOFT;
            end else if (w_int_timer) begin
                take_o = 1'b1; is_int_o = 1'b1; code_o = INT_TIMER;
            end else if (wb_excp_i[EXCP_IF_MISALIGN]) begin
                take_o = 1'b1; code_o = EXC_IF_MISALIGN; use_tval_o = 1'b1;
            end else if (wb_excp_i[EXCP_ILLEGAL]) begin
                take_o = 1'b1; code_o = EXC_ILLEGAL; use_tval_o = 1'b1;
            end else if (wb_excp_i[EXCP_EBREAK]) begin
                take_o = 1'b1; code_o = EXC_BREAK;
            end else if (wb_excp_i[EXCP_ECALL]) begin
                take_o = 1'b1; code_o = EXC_ECALL_M;
            end else if (wb_excp_i[EXCP_LD_MISALIGN]) begin
                take_o = 1'b1; code_o = EXC_LD_MISALIGN; use_tval_o = 1'b1;
            end else if (wb_excp_i[EXCP_ST_MISALIGN]) begin
                take_o = 1'b1; code_o = EXC_ST_MISALIGN; use_tval_o = 1'b1;
            end
        end
    end

endmodule : trap_prio_enc
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap controller: sequences trap-entry / mret CSR
//               writes, mstatus IE pulses, pipeline flush and PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic [5:0]      wb_excp_i,
    input  logic [XLEN-1:0] wb_tval_i,
    input  logic            wb_mret_i,
    input  logic            mstatus_ie_i,
    input  logic            mie_soft_i,
    input  logic            mie_timer_i,
    input  logic            mie_exter_i,
    input  logic            mip_soft_i,
    input  logic            mip_timer_i,
    input  logic            mip_exter_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            mcause_wen_o,
    output logic            mtval_wen_o,
    output logic            mepc_wen_o,
    output logic [XLEN-1:0] mcause_wdata_o,
    output logic [XLEN-1:0] mtval_wdata_o,
    output logic [XLEN-1:0] mepc_wdata_o,
    output logic            mstatus_ie_set_o,
    output logic            mstatus_ie_clear_o,
    output logic            wb_kill_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-3:0] r_epc;
    logic [XLEN-1:0] r_tval;
    logic            r_is_int;
    logic [3:0]      r_code;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_take;
    logic            w_is_int;
    logic [3:0]      w_code;
    logic            w_use_tval;
    logic            w_idle;
    logic [XLEN-1:0] w_mtvec_base;
    logic [XLEN-1:0] w_trap_target;

    trap_prio_enc u_prio_enc (
        .wb_valid_i   (wb_valid_i),
        .wb_excp_i    (wb_excp_i),
        .mstatus_ie_i (mstatus_ie_i),
        .mie_soft_i   (mie_soft_i),
        .mie_timer_i  (mie_timer_i),
        .mie_exter_i  (mie_exter_i),
        .mip_soft_i   (mip_soft_i),
        .mip_timer_i  (mip_timer_i),
        .mip_exter_i  (mip_exter_i),
        .take_o       (w_take),
        .is_int_o     (w_is_int),
        .code_o       (w_code),
        .use_tval_o   (w_use_tval)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign w_mtvec_base = {mtvec_i[XLEN-1:2], 2'b00};
    // Vectored mode offsets only interrupts; exceptions always land on base
    assign w_trap_target = ((mtvec_i[1:0] == 2'b01) && r_is_int)
                         ? w_mtvec_base + {{(XLEN-6){1'b0}}, r_code, 2'b00}
                         : w_mtvec_base;

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_take)
                    w_state_nxt = ST_TRAP_WR;
                else if (wb_valid_i && wb_mret_i)
                    w_state_nxt = ST_MRET_WR;
            end
            ST_TRAP_WR:  w_state_nxt = ST_TRAP_JMP;
            ST_MRET_WR:  w_state_nxt = ST_MRET_JMP;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_is_int      <= 1'b0;
            r_code        <= 4'd0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && w_take) begin
                r_cause  <= {w_is_int, {(XLEN-5){1'b0}}, w_code};
                r_epc    <= wb_pc_i[XLEN-1:2];
                r_tval   <= w_use_tval ? wb_tval_i : '0;
                r_is_int <= w_is_int;
                r_code   <= w_code;
            end
            // Target is captured one cycle ahead so the redirect comes from a flop
            if (r_state == ST_TRAP_WR)
                r_redirect_pc <= w_trap_target;
            else if (r_state == ST_MRET_WR)
                r_redirect_pc <= mepc_i;
        end
    end

    assign wb_kill_o          = w_idle & w_take;
    assign mcause_wen_o       = (r_state == ST_TRAP_WR);
    assign mtval_wen_o        = (r_state == ST_TRAP_WR);
    assign mepc_wen_o         = (r_state == ST_TRAP_WR);
    assign mstatus_ie_set_o   = (r_state == ST_TRAP_WR);
    assign mstatus_ie_clear_o = (r_state == ST_MRET_WR);
    assign flush_o            = ~w_idle;
    assign redirect_valid_o   = (r_state == ST_TRAP_JMP) || (r_state == ST_MRET_JMP);
    assign redirect_pc_o      = r_redirect_pc;
    assign mcause_wdata_o     = r_cause;
    assign mtval_wdata_o      = r_tval;
    assign mepc_wdata_o       = {r_epc, 2'b00};

endmodule : trap_ctrl
`default_nettype wire
